// File: rtl/cva6_tlb_refill_walker_sv32.sv
// cva6_tlb_refill_walker_sv32: Sv32 two-level page-table walker feeding the TLB update bus.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   flush_i                abort the walk in flight (no update or fault is issued for it)
//   satp_ppn_i             root page-table PPN, captured when a miss is accepted
//   miss_valid_i/ready_o   miss handshake; miss_vaddr_i / miss_asid_i describe the miss
//   mem_req_o/addr_o/gnt_i PTE read request channel (one read outstanding at most)
//   mem_rvalid_i/rdata_i   PTE read response
//   update_o               {valid, is_4M, vpn[19:0], asid[8:0], pte[31:0]}, one-cycle pulse
//   fault_o                one-cycle page-fault pulse
//   busy_o                 walker not idle
module cva6_tlb_refill_walker_sv32 #(
    parameter int unsigned ASID_WIDTH = 1,
    parameter int unsigned PPN_WIDTH  = 22
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [PPN_WIDTH-1:0]  satp_ppn_i,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [31:0]           miss_vaddr_i,
    input  logic [ASID_WIDTH-1:0] miss_asid_i,
    output logic                  mem_req_o,
    output logic [PPN_WIDTH+11:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    output logic [62:0]           update_o,
    output logic                  fault_o,
    output logic                  busy_o
);
    localparam int AW = PPN_WIDTH + 12;

    typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE, FAULT, ABORT} state_e;

    state_e                state_q;
    logic [19:0]           vpn_q;
    logic [ASID_WIDTH-1:0] asid_q;
    logic                  req_q;
    logic [AW-1:0]         addr_q;
    logic [62:0]           update_q;
    logic                  fault_q;
    logic                  pte_bad;
    logic                  pte_leaf;
    logic                  pte_misaligned;
    logic                  unused_vaddr;

    // Invalid, or the reserved write-without-read encoding.
    assign pte_bad        = !mem_rdata_i[0] || (!mem_rdata_i[1] && mem_rdata_i[2]);
    assign pte_leaf       = mem_rdata_i[1] || mem_rdata_i[3];
    // A 4M superpage must have its low PPN bits clear.
    assign pte_misaligned = |mem_rdata_i[19:10];
    assign unused_vaddr   = ^miss_vaddr_i[11:0];

    assign miss_ready_o = (state_q == IDLE) && !flush_i;
    assign busy_o       = (state_q != IDLE);
    assign mem_req_o    = req_q;
    assign mem_addr_o   = addr_q;
    assign update_o     = update_q;
    assign fault_o      = fault_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            vpn_q    <= '0;
            asid_q   <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            update_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            update_q <= '0;
            fault_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (miss_valid_i && !flush_i) begin
                        vpn_q   <= miss_vaddr_i[31:12];
                        asid_q  <= miss_asid_i;
                        req_q   <= 1'b1;
                        addr_q  <= {satp_ppn_i, miss_vaddr_i[31:22], 2'b00};
                        state_q <= L1_REQ;
                    end
                end
                L1_REQ, L0_REQ: begin
                    // Once granted, a response is owed even if the walk is flushed.
                    if (mem_gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= flush_i ? ABORT : (state_q == L1_REQ ? L1_WAIT : L0_WAIT);
                    end else if (flush_i) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                L1_WAIT: begin
                    if (flush_i) begin
                        state_q <= mem_rvalid_i ? IDLE : ABORT;
                    end else if (mem_rvalid_i) begin
                        if (pte_bad || (pte_leaf && pte_misaligned)) begin
                            fault_q <= 1'b1;
                            state_q <= FAULT;
                        end else if (pte_leaf) begin
                            update_q <= {1'b1, 1'b1, vpn_q, 9'(asid_q), mem_rdata_i};
                            state_q  <= DONE;
                        end else begin
                            req_q   <= 1'b1;
                            addr_q  <= AW'({mem_rdata_i[31:10], vpn_q[9:0], 2'b00});
                            state_q <= L0_REQ;
                        end
                    end
                end
                L0_WAIT: begin
                    if (flush_i) begin
                        state_q <= mem_rvalid_i ? IDLE : ABORT;
                    end else if (mem_rvalid_i) begin
                        if (pte_bad || !pte_leaf) begin
                            fault_q <= 1'b1;
                            state_q <= FAULT;
                        end else begin
                            update_q <= {1'b1, 1'b0, vpn_q, 9'(asid_q), mem_rdata_i};
                            state_q  <= DONE;
                        end
                    end
                end
                DONE, FAULT: state_q <= IDLE;
                ABORT: if (mem_rvalid_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
